// File: rtl/mul16_seq_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mul16_seq_pkg : state type and sizing constants for the 16-bit multiplier |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
package mul16_seq_pkg;

  localparam int WIDTH = 16;  // datapath width, matches the shared adder
  localparam int STEPS = 16;  // shift-add steps for a full multiplier scan
  localparam int CNT_W = 5;   // step counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mul16_seq_add16.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mul16_seq_add16 : 16-bit modulo adder, no carry-out                       |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module mul16_seq_add16
  import mul16_seq_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule
`default_nettype wire

// File: rtl/mul16_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mul16_seq : shift-add 16x16 multiplier, low 16 bits; MUL16_EARLY_EXIT_EN  |
// | ends RUN once the multiplier runs out of set bits. Revision 1.0           |
// +---------------------------------------------------------------------------+
module mul16_seq
  import mul16_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              ready,
  output logic              done,
  output logic [WIDTH-1:0]  product
);

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   acc_next;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_inc;
  logic               exit_now;
  logic               last_step;

  mul16_seq_add16 u_add16 (
    .a   (acc),
    .b   (mcand),
    .sum (sum)
  );

  assign acc_next  = mplier[0] ? sum : acc;
  assign count_inc = count + CNT_W'(1);

`ifdef MUL16_EARLY_EXIT_EN
  // Once all multiplier bits are consumed further steps cannot change acc.
  assign exit_now  = (mplier == '0);
  assign last_step = 1'b0;
`else
  assign exit_now  = 1'b0;
  assign last_step = (count == CNT_W'(STEPS - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            ready  <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (exit_now) begin
            product <= acc;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            acc    <= acc_next;
            mcand  <= {mcand[WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            count  <= count_inc;
            if (last_step) begin
              product <= acc_next;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul16_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_mul16_seq : directed literal cases plus randomized traffic vs a model  |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_mul16_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ready;
  logic        done;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;

`ifdef MUL16_EARLY_EXIT_EN
  localparam int L_3X5 = 5,  L_FFFF = 18, L_0100 = 11, L_7X6 = 5,  L_9X9 = 6;
  localparam int L_B0  = 2,  L_B1   = 3,  L_B8000 = 18, L_2X3 = 4, R_OFS = 3;
`else
  localparam int L_3X5 = 17, L_FFFF = 17, L_0100 = 17, L_7X6 = 17, L_9X9 = 17;
  localparam int L_B0  = 17, L_B1   = 17, L_B8000 = 17, L_2X3 = 17, R_OFS = 8;
`endif

  mul16_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Cycles from the accept cycle to the done cycle.
  function automatic int latency(input logic [15:0] bv);
`ifdef MUL16_EARLY_EXIT_EN
    for (int i = 15; i >= 0; i--)
      if (bv[i]) return 3 + i;
    return 2;
`else
    return (bv === 16'hxxxx) ? 17 : 17;
`endif
  endfunction

  // Behavioural model: expected outputs for the cycle after the next edge.
  logic        m_ready = 1'b1;
  logic        m_done  = 1'b0;
  logic [15:0] m_prod  = '0;
  logic [15:0] m_res   = '0;
  int          m_left  = 0;
  bit          m_valid = 0;

  initial forever begin
    logic [31:0] p;
    @(negedge clk);
    if (m_valid) begin
      check("cyc_ready", ready, m_ready);
      check("cyc_done", done, m_done);
      check("cyc_product", product, m_prod);
    end
    if (reset) begin
      m_ready = 1'b1; m_done = 1'b0; m_prod = '0; m_left = 0; m_valid = 1;
    end else if (m_done) begin
      m_done = 1'b0; m_ready = 1'b1;
    end else if (m_ready) begin
      if (start) begin
        p = {16'h0, a} * {16'h0, b};
        m_res = p[15:0];
        m_left = latency(b) - 1;
        m_ready = 1'b0;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_prod = m_res;
      end
    end
  end

  task automatic run_op(input string name, input logic [15:0] ia, input logic [15:0] ib,
                        input int lat, input logic [15:0] prod);
    int n;
    bit busy_ok;
    n = 0;
    while (!ready && n < 40) begin tick; n++; end
    check({name, "_ready_before"}, ready, 1);
    start = 1'b1; a = ia; b = ib;
    tick;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    n = 1; busy_ok = 1;
    while (!done && n < 40) begin
      if (ready) busy_ok = 0;
      tick;
      n++;
    end
    check({name, "_latency"}, n, lat);
    check({name, "_busy"}, busy_ok, 1);
    check({name, "_product"}, product, prod);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int n, first, second, pulses;
    reset = 1'b1;
    tick; tick;
    check("reset_ready", ready, 1);
    check("reset_done", done, 0);
    check("reset_product", product, 16'h0000);
    reset = 1'b0;
    tick;

    run_op("basic_3x5", 16'd3, 16'd5, L_3X5, 16'h000F);
    run_op("wrap_ffff", 16'hFFFF, 16'hFFFF, L_FFFF, 16'h0001);
    run_op("wrap_0100", 16'h0100, 16'h0100, L_0100, 16'h0000);
    run_op("b_zero", 16'h5A5A, 16'h0000, L_B0, 16'h0000);
    run_op("b_one", 16'h1234, 16'h0001, L_B1, 16'h1234);
    run_op("b_8000", 16'h0001, 16'h8000, L_B8000, 16'h8000);

    // Busy: a stray start and wiggling operands during RUN.
    tick;
    start = 1'b1; a = 16'd7; b = 16'd6;
    tick;
    pulses = 0; first = -1;
    for (int c = 1; c < 25; c++) begin
      start = (c == 5);
      a = (c == 5) ? 16'd2 : 16'($urandom);
      b = (c == 5) ? 16'd2 : 16'($urandom);
      if (done) begin
        pulses++;
        if (first < 0) first = c;
        check("busy_product", product, 16'h002A);
      end
      tick;
    end
    start = 1'b0;
    check("busy_pulses", pulses, 1);
    check("busy_done_cycle", first, L_7X6);

    // Reset in the middle of a 9x9.
    start = 1'b1; a = 16'd9; b = 16'd9;
    tick;
    start = 1'b0;
    pulses = 0;
    for (int c = 1; c < R_OFS; c++) begin
      if (done) pulses++;
      tick;
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort_no_done", pulses, 0);
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    check("abort_product", product, 16'h0000);
    run_op("after_abort_9x9", 16'd9, 16'd9, L_9X9, 16'h0051);

    // Back-to-back with start held high.
    tick;
    start = 1'b1; a = 16'd2; b = 16'd3;
    tick;
    first = -1; second = -1;
    for (int c = 1; c < 2 * L_2X3 + 4; c++) begin
      if (done) begin
        check("b2b_product", product, 16'h0006);
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      tick;
    end
    start = 1'b0;
    check("b2b_first", first, L_2X3);
    check("b2b_second", second, 2 * L_2X3 + 1);
    for (int c = 0; c < 20; c++) tick;

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      n = int'($urandom_range(0, 7));
      case (n)
        0: a = 16'hFFFF;
        1: a = 16'h0001 << $urandom_range(0, 15);
        default: a = 16'($urandom);
      endcase
      n = int'($urandom_range(0, 9));
      case (n)
        0: b = 16'h0000;
        1: b = 16'hFFFF;
        2: b = 16'h0001 << $urandom_range(0, 15);
        3: b = 16'($urandom_range(0, 15));
        default: b = 16'($urandom);
      endcase
      start = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 120) == 0);
      tick;
    end
    reset = 1'b0;
    start = 1'b0;
    tick; tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul16_seq.md
MUL16_SEQ -- requirements
Module: mul16_seq

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 16 bits, matching the shared adder.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply; sampled only while ready=1.
REQ-005 The block SHALL have ports a and b, input, 16 bits each: multiplicand and multiplier, captured on accept.
REQ-006 The block SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-007 The block SHALL have port done, output, 1 bit: single-cycle pulse, high only in DONE.
REQ-008 The block SHALL have port product, output, 16 bits: registered result, low 16 bits of a*b.

Function
REQ-009 The FSM SHALL have states IDLE, RUN and DONE.
REQ-010 Transitions SHALL be: IDLE->RUN on start=1; RUN->DONE after the final step; DONE->IDLE unconditionally after one cycle.
REQ-011 Accept: if start=1 in IDLE at cycle k, the block SHALL latch mcand=a, mplier=b, acc=0 and step count=0, and enter RUN at k+1.
REQ-012 Each RUN cycle SHALL perform one step: if mplier[0]=1 then acc<=acc+mcand through the Add16 instance, else acc is unchanged; mcand<=mcand<<1 (bit 15 dropped); mplier<=mplier>>1 (zero fill); count increments.
REQ-013 Arithmetic SHALL be modulo 2^16: the adder has no carry-out, and bits above 15 are discarded silently, with no overflow flag.
REQ-014 The Add16 instance SHALL be the only adder in the block; the step counter uses a separate 5-bit incrementer.
REQ-015 Without early exit, RUN SHALL last exactly 16 cycles (k+1..k+16); DONE is at k+17 with done=1, and ready=1 again at k+18.
REQ-016 On entry to DONE, product SHALL load acc; product then holds until the next DONE or reset.
REQ-017 While not in IDLE, start SHALL be ignored; changes on a and b after accept SHALL NOT affect the result.
REQ-018 start held high continuously SHALL cause back-to-back operations, each accepted on its IDLE cycle.

Reset
REQ-019 reset=1 SHALL force state=IDLE, ready=1, done=0, product=0x0000, and acc, mcand, mplier and count to 0.
REQ-020 reset SHALL take priority over start and over any RUN step in the same cycle.
REQ-021 reset during RUN SHALL abort with no done pulse; the partial result SHALL be discarded and product SHALL read 0.

Configuration
REQ-022 The macro MUL16_EARLY_EXIT_EN, when defined, SHALL make RUN check mplier==0 at the start of each cycle; if it is zero, the block SHALL do no add and move to DONE at the next cycle.
REQ-023 With MUL16_EARLY_EXIT_EN defined, done SHALL occur at k+2 for b=0 and at k+3+msb(b) otherwise, where msb(b) is the bit index 0..15.
REQ-024 With MUL16_EARLY_EXIT_EN undefined, latency SHALL always be 17 cycles (REQ-015); product values SHALL be identical in both builds.

Structure
REQ-025 A shared package SHALL hold the state typedef (IDLE, RUN, DONE), the width constant 16, the step count 16, and the count width 5.
REQ-026 The block SHALL contain one sub-module instance: the existing Add16, with a=acc, b=mcand and sum feeding the acc mux.

Verification
REQ-027 Basic case: a=3, b=5, start at k -> done=1 at k+17 (no macro), product=0x000F, ready=0 from k+1 to k+17.
REQ-028 Wrap-around: a=0xFFFF, b=0xFFFF -> product=0x0001; a=0x0100, b=0x0100 -> product=0x0000.
REQ-029 Busy and operand isolation: accept a=7, b=6; pulse start with a=2, b=2 at k+5; change a and b every cycle -> a single done at k+17 with product=0x002A.
REQ-030 Reset mid-operation: reset at k+8 during a=9, b=9 -> no done, product=0, ready=1 at k+9; a new start at k+9 with a=9, b=9 -> product=0x0051 at k+26.
REQ-031 Early exit (macro defined): b=0 -> done at k+2, product=0; b=1, a=0x1234 -> done at k+3, product=0x1234; b=0x8000, a=1 -> done at k+18, product=0x8000.
REQ-032 Back-to-back: start held high with a=2, b=3 -> done pulses at k+17 and k+35, product=0x0006 each time.
